oled_screen_sequencer: RTL

Frame-synchronous controller that sequences the celebration screen onto the 96x64 OLED. It accepts a celebration request and runs a timed flash-then-hold sequence. It selects which RGB565 source (game screen, congrats screen, or solid black) drives `oled_data`. Source changes happen only on OLED frame boundaries to prevent tearing. It sits between the screen renderers and the OLED driver, and also drives the `celebrationState` enable of the congrats renderer.

---
 rtl/oled_pkg.sv | 33 +++
 rtl/oled_screen_sequencer_if.sv | 24 ++
 rtl/oled_frame_counter.sv | 28 ++
 rtl/oled_screen_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED screen sequencer.
// Screen sources, sequencer states and RGB565 colours.
package oled_pkg;

    typedef enum logic [1:0] {
        GAME,
        CONGRATS,
        BLACK
    } screen_src_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FLASH,
        HOLD,
        RELEASE,
        DONE
    } seq_state_t;

    localparam logic [15:0] COLOUR_BLACK = 16'h0000;
    localparam logic [15:0] COLOUR_RED   = 16'hF800;
    localparam logic [15:0] COLOUR_GREEN = 16'h07E0;
    localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;

    // Width for a counter that must hold values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/oled_screen_sequencer_if.sv
// Celebration request/acknowledge handshake between game logic and sequencer.
// The master raises the request; the slave reports busy and pulses ack.
interface oled_screen_sequencer_if;

    logic celebrate_req;
    logic cancel;
    logic celebrate_ack;
    logic busy;

    modport master (
        output celebrate_req,
        output cancel,
        input  celebrate_ack,
        input  busy
    );

    modport slave (
        input  celebrate_req,
        input  cancel,
        output celebrate_ack,
        output busy
    );

endinterface

// File: rtl/oled_frame_counter.sv
// Counts frame_begin pulses up to a runtime terminal value.
// tc is a one-cycle pulse on the pulse that reaches term; the count self-clears.
module oled_frame_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    assign tc = en && (count == term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tc) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/oled_screen_sequencer.sv
// Frame-synchronous flash-then-hold celebration sequencer for the 96x64 OLED.
// Source changes only on frame_begin so a frame never mixes two screens.
module oled_screen_sequencer
    import oled_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int NUM_FLASHES  = 3,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_begin,
    oled_screen_sequencer_if.slave ctl,
    input  logic [15:0]           game_pixel,
    input  logic [15:0]           congrats_pixel,
    output logic [15:0]           oled_data,
    output logic                  celebrationState
);

    localparam int MAXF = (FLASH_FRAMES > HOLD_FRAMES) ? FLASH_FRAMES : HOLD_FRAMES;
    localparam int CW = cnt_w(MAXF);
    localparam int PW = cnt_w(2 * NUM_FLASHES);

    localparam logic [CW-1:0] FLASH_TERM = CW'(FLASH_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_TERM  = CW'(HOLD_FRAMES - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * NUM_FLASHES - 1);

    seq_state_t    state, state_n;
    screen_src_t   sel, sel_n;
    logic [PW-1:0] phase, phase_n;
    logic [15:0]   pix_n;
    logic          ack_q, ack_n;
    logic          busy_q, busy_n;
    logic          cnt_clr, tc;
    logic [CW-1:0] term;

    oled_frame_counter #(.W(CW)) u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (frame_begin),
        .term (term),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= GAME;
            phase     <= '0;
            oled_data <= COLOUR_BLACK;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            phase     <= phase_n;
            oled_data <= pix_n;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        phase_n = phase;
        unique case (state)
            IDLE: begin
                if (ctl.celebrate_req && !ctl.cancel) state_n = ARM;
            end
            ARM: begin
                if (ctl.cancel) begin
                    state_n = DONE;
                end else if (frame_begin) begin
                    state_n = FLASH;
                    sel_n   = CONGRATS;
                    phase_n = '0;
                end
            end
            FLASH: begin
                if (ctl.cancel && frame_begin) begin
                    state_n = DONE;
                    sel_n   = GAME;
                end else if (ctl.cancel) begin
                    state_n = RELEASE;
                end else if (tc && phase == LAST_PHASE) begin
                    state_n = HOLD;
                    sel_n   = CONGRATS;
                end else if (tc) begin
                    // odd phases show black, even phases congrats
                    phase_n = phase + 1'b1;
                    sel_n   = phase[0] ? CONGRATS : BLACK;
                end
            end
            HOLD: begin
                if (ctl.cancel && !frame_begin) begin
                    state_n = RELEASE;
                end else if (ctl.cancel || tc) begin
                    state_n = DONE;
                    sel_n   = GAME;
                end
            end
            RELEASE: begin
                if (frame_begin) begin
                    state_n = DONE;
                    sel_n   = GAME;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_n   = (state_n == DONE);
        busy_n  = (state_n != IDLE);
        cnt_clr = !(state == FLASH || state == HOLD);
        term    = (state == HOLD) ? HOLD_TERM : FLASH_TERM;
        unique case (1'b1)
            sel == GAME:     pix_n = game_pixel;
            sel == CONGRATS: pix_n = congrats_pixel;
            default:         pix_n = COLOUR_BLACK;
        endcase
    end

    assign ctl.celebrate_ack  = ack_q;
    assign ctl.busy           = busy_q;
    assign celebrationState   = (sel != GAME);

endmodule
